// File: rtl/cfi_pkg.sv
// cfi_pkg: shared types for the CFI event sequencer slice
// (event kinds, packed event record, sequencer FSM states).
package cfi_pkg;

    localparam int unsigned CFI_PC_W = 64;

    typedef enum logic [1:0] {
        CALL   = 2'd0,
        RET    = 2'd1,
        JUMP   = 2'd2,
        BRANCH = 2'd3
    } cfi_kind_e;

    typedef struct packed {
        cfi_kind_e             kind;
        logic [CFI_PC_W-1:0]   pc;
        logic [CFI_PC_W-1:0]   target;
    } cfi_event_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ALERT = 2'd1,
        DRAIN = 2'd2
    } cfi_seq_state_e;

endpackage

// File: rtl/cfi_event_sequencer_if.sv
// cfi_event_sequencer_if: valid/ready event stream from the sequencer
// (master) to the CFI checker (slave).
interface cfi_event_sequencer_if #(
    parameter int unsigned PC_W = 64
);
    import cfi_pkg::*;

    logic            ev_valid_o;
    logic            ev_ready_i;
    cfi_kind_e       ev_kind_o;
    logic [PC_W-1:0] ev_pc_o;
    logic [PC_W-1:0] ev_target_o;

    modport master (
        output ev_valid_o,
        output ev_kind_o,
        output ev_pc_o,
        output ev_target_o,
        input  ev_ready_i
    );

    modport slave (
        input  ev_valid_o,
        input  ev_kind_o,
        input  ev_pc_o,
        input  ev_target_o,
        output ev_ready_i
    );
endinterface

// File: rtl/cfi_event_fifo.sv
// cfi_event_fifo: NR_PORTS-write, single-read FIFO. Writes are packed in
// ascending port order; requests beyond the free space (measured before
// any same-cycle read) are dropped youngest-first and flagged on o_drop.
module cfi_event_fifo #(
    parameter  int unsigned NR_PORTS = 2,
    parameter  int unsigned DEPTH    = 4,
    parameter  int unsigned DW       = 130,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         i_flush,
    input  logic [NR_PORTS-1:0]          i_wr_en,
    input  logic [NR_PORTS-1:0][DW-1:0]  i_wr_data,
    input  logic                         i_rd_en,
    output logic [DW-1:0]                o_rd_data,
    output logic [CW-1:0]                o_count,
    output logic [CW-1:0]                o_free,
    output logic                         o_drop
);

    logic [DW-1:0]               r_mem [DEPTH];
    logic [AW-1:0]               r_wr_ptr;
    logic [AW-1:0]               r_rd_ptr;
    logic [CW-1:0]               r_count;
    logic [CW-1:0]               w_free;
    logic [CW-1:0]               w_rank;
    logic [NR_PORTS-1:0]         w_acc;
    logic [NR_PORTS-1:0][AW-1:0] w_slot;
    logic                        w_rd;

    assign w_free    = CW'(DEPTH) - r_count;
    assign w_rd      = i_rd_en && (r_count != '0);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_free    = w_free;

    // Rank each requesting port; accept while free slots remain.
    always_comb begin
        w_rank = '0;
        w_acc  = '0;
        w_slot = '0;
        o_drop = 1'b0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            w_slot[p] = r_wr_ptr + w_rank[AW-1:0];
            if (i_wr_en[p] && !i_flush) begin
                if (w_rank < w_free) begin
                    w_acc[p] = 1'b1;
                    w_rank   = w_rank + CW'(1);
                end else begin
                    o_drop = 1'b1;
                end
            end
        end
    end

    // Pointer and occupancy update; flush overrides same-cycle traffic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_rank[AW-1:0];
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + w_rank - CW'(w_rd);
        end
    end

    // Accepted events land in consecutive slots in port order.
    always_ff @(posedge clk_i) begin
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            if (w_acc[p]) begin
                r_mem[w_slot[p]] <= i_wr_data[p];
            end
        end
    end

endmodule

// File: rtl/cfi_event_sequencer.sv
// cfi_event_sequencer: serializes commit-port control-flow events into a
// single valid/ready stream for the CFI checker and sequences the violation
// alert (RUN -> ALERT -> DRAIN -> RUN).
// Optional: define CFI_ALERT_COUNT_EN to add the saturating alert_count_o.
module cfi_event_sequencer
    import cfi_pkg::*;
#(
    parameter int unsigned NR_PORTS   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PC_W       = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cfg_en_i,
    input  logic [NR_PORTS-1:0]      commit_ack_i,
    input  logic [NR_PORTS-1:0]      commit_is_cf_i,
    input  logic [NR_PORTS*2-1:0]    commit_kind_i,
    input  logic [NR_PORTS*PC_W-1:0] commit_pc_i,
    input  logic [NR_PORTS*PC_W-1:0] commit_target_i,
    output logic                     commit_stall_o,
    cfi_event_sequencer_if.master    ev_if,
    input  logic                     chk_fail_i,
    output logic                     alert_req_o,
    input  logic                     alert_ack_i,
    output logic                     overflow_o
`ifdef CFI_ALERT_COUNT_EN
    ,
    output logic [15:0]              alert_count_o
`endif
);

    localparam int unsigned DW = 2 + 2 * PC_W;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    cfi_seq_state_e              r_state;
    logic                        r_alert_req;
    logic                        r_overflow;
    logic [NR_PORTS-1:0]         w_wr_en;
    logic [NR_PORTS-1:0][DW-1:0] w_wr_data;
    logic [DW-1:0]               w_head;
    logic [CW-1:0]               w_count;
    logic [CW-1:0]               w_free;
    logic                        w_empty;
    logic                        w_flush;
    logic                        w_ev_valid;
    logic                        w_deq;
    logic                        w_drop;

    assign w_wr_en    = {NR_PORTS{cfg_en_i}} & commit_ack_i & commit_is_cf_i;
    assign w_flush    = !cfg_en_i || (r_state == DRAIN);
    assign w_empty    = (w_count == '0);
    assign w_ev_valid = (r_state == RUN) && !w_empty;
    assign w_deq      = w_ev_valid && ev_if.ev_ready_i;

    // Pack each port's event as {kind, pc, target}.
    always_comb begin
        w_wr_data = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            w_wr_data[p] = {commit_kind_i[2*p +: 2],
                            commit_pc_i[p*PC_W +: PC_W],
                            commit_target_i[p*PC_W +: PC_W]};
        end
    end

    cfi_event_fifo #(
        .NR_PORTS (NR_PORTS),
        .DEPTH    (FIFO_DEPTH),
        .DW       (DW)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_flush   (w_flush),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_deq),
        .o_rd_data (w_head),
        .o_count   (w_count),
        .o_free    (w_free),
        .o_drop    (w_drop)
    );

    assign ev_if.ev_valid_o  = w_ev_valid;
    assign ev_if.ev_kind_o   = cfi_kind_e'(w_head[DW-1 -: 2]);
    assign ev_if.ev_pc_o     = w_head[2*PC_W-1 -: PC_W];
    assign ev_if.ev_target_o = w_head[PC_W-1:0];

    assign commit_stall_o = cfg_en_i && (w_free < CW'(NR_PORTS));
    assign alert_req_o    = r_alert_req;
    assign overflow_o     = r_overflow;

    // Violation sequencing FSM with registered alert and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= RUN;
            r_alert_req <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (!cfg_en_i) begin
            r_state     <= RUN;
            r_alert_req <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            unique case (r_state)
                RUN: begin
                    if (chk_fail_i) begin
                        r_state     <= ALERT;
                        r_alert_req <= 1'b1;
                    end
                end
                ALERT: begin
                    if (alert_ack_i) begin
                        r_state     <= DRAIN;
                        r_alert_req <= 1'b0;
                    end
                end
                DRAIN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state     <= RUN;
                    r_alert_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef CFI_ALERT_COUNT_EN
    logic [15:0] r_alert_count;

    // Saturating count of RUN->ALERT transitions; survives cfg_en_i low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_alert_count <= '0;
        end else if (cfg_en_i && (r_state == RUN) && chk_fail_i &&
                     (r_alert_count != '1)) begin
            r_alert_count <= r_alert_count + 16'd1;
        end
    end

    assign alert_count_o = r_alert_count;
`endif

endmodule
